int8_matvec: RTL and testbench
==============================

# int8_matvec

Sequential signed INT8 matrix-vector multiplier: computes out = sat8((W · x) >>> SHIFT) for an OUT_DIM×IN_DIM weight matrix held in external memory and an IN_DIM-element input vector. It performs one multiply-accumulate per clock and drives a flat weight address to an external zero-latency (combinational-read) weight store. Used for transformer projection layers, e.g. 128×128 attention projection.

## Interface

- IN_DIM, 128: input vector length (elements).
- OUT_DIM, 128: output vector length (matrix rows).
- SHIFT, 0: arithmetic right shift applied to each accumulator before saturation.
- AW, $clog2(IN_DIM*OUT_DIM) (14 by default): weight address width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  one-cycle request to begin a computation; sampled in IDLE only.
- in_vec  in  IN_DIM*8  packed signed int8 vector; element j is in_vec[j*8 +: 8].
- weight_addr  out  AW  flat weight index, row-major: row*IN_DIM + col.
- weight_data  in  8  signed int8 weight at weight_addr, valid combinationally in the same cycle.
- out_vec  out  OUT_DIM*8  packed signed int8 result; element i is out_vec[i*8 +: 8].
- done  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: weight_addr = 0. On start = 1, latch in_vec into an internal register, clear row/col counters and the accumulator, go to RUN. in_vec may change after the start cycle.
- RUN: each cycle, weight_addr = row*IN_DIM + col; acc += x[col] * weight_data (signed 8×8 = 16-bit product, 32-bit signed accumulator).
  - If col < IN_DIM-1: col++.
  - If col == IN_DIM-1: r = (acc + product) >>> SHIFT; out_vec[row] = saturated r; acc = 0; col = 0; row++. After row OUT_DIM-1, go to DONE.
- Saturation: r > 127 → 127; r < −128 → −128; otherwise the low 8 bits.
- DONE: done = 1 for exactly one cycle, then IDLE.
- out_vec rows update as they complete and hold their values until the corresponding row is rewritten by a later run.
- start in RUN or DONE is ignored. No queuing.
- Reset at any time, including mid-RUN, returns to IDLE immediately. It clears out_vec, the accumulator, the counters and done, and sets weight_addr = 0.

## Timing

- Reset values: out_vec = 0, done = 0, weight_addr = 0, state IDLE.
- start sampled at edge E0. RUN occupies the IN_DIM*OUT_DIM cycles after E0, one MAC per cycle.
- done is high in the cycle after the last MAC, i.e. registered high at edge E0 + IN_DIM*OUT_DIM + 1. For 128×128 this is 16385 edges after E0.
- out_vec is complete and stable when done is high and remains stable while in IDLE.
- weight_addr is registered. It advances by exactly 1 per RUN cycle, from 0 to IN_DIM*OUT_DIM−1, with no gaps or repeats.
- The weight store must be combinational; with a registered read the results are off by one element.
- A new start is accepted on the cycle after DONE.

## Test plan

- Reset with 128×128 weights W[r][c] = (r+c) mod 3 − 1 and all-ones input: after done, every out[r] equals the row sum clamped to the int8 range; no X/Z values on out_vec; done pulses for exactly one cycle, 16385 edges after start.
- Identity weights (W[r][r] = 1, others 0) and input x[j] = j − 64: out[j] = j − 64 for all j; weight_addr sweeps 0..16383 monotonically.
- Saturation:
  - all weights 127, input all 1: every out = 127 (sum 16256).
  - all weights −128, input all 1: every out = −128.
  - all weights 127, input all −1: every out = −128.
- All-zero weights with random input: every out = 0. Then a second back-to-back run with identity weights: correct results, and start during RUN has no effect.
- Assert rst low mid-RUN (cycle 5000): out_vec = 0, done = 0, weight_addr = 0 immediately. A subsequent start produces a full, correct result.
- SHIFT = 7, all weights 64, input all 2: acc = 16384, shifted = 128, out = 127. Same with input all −2: out = −128.

Source files
------------

// File: rtl/int8_matvec.sv
// rtl/int8_matvec.sv - sequential signed int8 matrix-vector multiplier, one MAC per clock
// Streams weights row-major from a combinational store; each row result is shifted and saturated to int8.
module int8_matvec #(
  parameter int IN_DIM  = 128,
  parameter int OUT_DIM = 128,
  parameter int SHIFT   = 0,
  parameter int AW      = $clog2(IN_DIM * OUT_DIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_DIM*8-1:0]  in_vec,
  output logic [AW-1:0]        weight_addr,
  input  logic [7:0]           weight_data,
  output logic [OUT_DIM*8-1:0] out_vec,
  output logic                 done
);
  localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int RW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_DIM - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [IN_DIM*8-1:0] x_reg;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic signed [31:0]  acc;
  logic signed [7:0]   x_elem;
  logic signed [15:0]  product;
  logic signed [31:0]  sum;
  logic signed [31:0]  shifted;
  logic [7:0]          sat;
  logic                row_end;
  logic                last_mac;

  always_comb begin
    x_elem   = x_reg[{col, 3'b000} +: 8];
    product  = 16'(x_elem) * 16'($signed(weight_data));
    sum      = acc + 32'(product);
    shifted  = sum >>> SHIFT;
    row_end  = (col == COL_LAST);
    last_mac = row_end && (row == ROW_LAST);
    if (shifted > 127)
      sat = 8'h7f;
    else if (shifted < -128)
      sat = 8'h80;
    else
      sat = shifted[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_mac) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg       <= '0;
      col         <= '0;
      row         <= '0;
      acc         <= '0;
      weight_addr <= '0;
      out_vec     <= '0;
      done        <= 1'b0;
    end else begin
      // done is registered from the DONE state so it lands one cycle after the last MAC
      done <= (state == DONE);
      case (state)
        IDLE: begin
          weight_addr <= '0;
          if (start) begin
            x_reg <= in_vec;
            col   <= '0;
            row   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (row_end) begin
            out_vec[{row, 3'b000} +: 8] <= sat;
            acc <= '0;
            col <= '0;
            row <= row + RW'(1);
          end else begin
            acc <= sum;
            col <= col + CW'(1);
          end
          weight_addr <= last_mac ? '0 : weight_addr + AW'(1);
        end
        default: weight_addr <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_int8_matvec.sv
// tb/tb_int8_matvec.sv - directed self-checking bench for int8_matvec
// Two 128x128 instances (shift 0 and 7) share runs; a small 8x4 instance covers saturation and back-to-back runs.
module tb_int8_matvec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_a, start_b, start_c;
  logic [1023:0] in_a, in_b;
  logic [63:0]   in_c;
  logic [13:0]   wa_a, wa_b;
  logic [4:0]    wa_c;
  logic [7:0]    wd_a, wd_b, wd_c;
  logic [1023:0] out_a, out_b;
  logic [31:0]   out_c;
  logic          done_a, done_b, done_c;
  int            mode_a, mode_c;

  int n_asrt = 0;
  int n_fail = 0;
  int lat, bad;
  logic [1023:0] exp_v;

  int8_matvec dut_a (.clk(clk), .rst(rst), .start(start_a), .in_vec(in_a), .weight_addr(wa_a),
                     .weight_data(wd_a), .out_vec(out_a), .done(done_a));
  int8_matvec #(.SHIFT(7)) dut_b (.clk(clk), .rst(rst), .start(start_b), .in_vec(in_b),
                     .weight_addr(wa_b), .weight_data(wd_b), .out_vec(out_b), .done(done_b));
  int8_matvec #(.IN_DIM(8), .OUT_DIM(4)) dut_c (.clk(clk), .rst(rst), .start(start_c), .in_vec(in_c),
                     .weight_addr(wa_c), .weight_data(wd_c), .out_vec(out_c), .done(done_c));

  function automatic logic [7:0] w_a(input logic [13:0] a, input int mode);
    int r, c;
    r = int'(a[13:7]);
    c = int'(a[6:0]);
    if (mode == 0) return 8'((r + c) % 3 - 1);
    return (r == c) ? 8'd1 : 8'd0;
  endfunction

  assign wd_a = w_a(wa_a, mode_a);
  assign wd_b = 8'd64;
  assign wd_c = (mode_c == 0) ? 8'd127 :
                (mode_c == 1) ? 8'h80 :
                (mode_c == 2) ? 8'd0 :
                (({1'b0, wa_c[4:3]} == wa_c[2:0]) ? 8'd1 : 8'd0);

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int k;
    n_asrt++;
    assert (obs === exp) else begin
      k = 0;
      while (k < 127 && obs[k*8 +: 8] === exp[k*8 +: 8]) k++;
      n_fail++;
      $error("FAIL %s: observed %h expected %h (first differing byte %0d)", tag, obs[k*8 +: 8], exp[k*8 +: 8], k);
    end
  endtask

  // Starts A (optionally B alongside), counts edges from the start edge until done, checks the address sweep
  task automatic run_a(input logic with_b, output int n, output int nbad);
    @(negedge clk);
    start_a = 1'b1;
    start_b = with_b;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    nbad = (wa_a !== 14'd0) ? 1 : 0;
    while (done_a !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (n <= 16383 && wa_a !== 14'(n)) nbad++;
    end
  endtask

  task automatic run_c(input logic poke, output int n);
    @(negedge clk);
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    n = 0;
    while (done_c !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      start_c = poke && (n == 10);
      if (poke && n == 10) in_c = ~in_c;
    end
    start_c = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    mode_a = 0; mode_c = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_a", out_a, '0);
    check("reset done_a", done_a, 0);
    check("reset addr_a", wa_a, 0);
    check("reset out_c", out_c, '0);
    @(negedge clk);
    rst = 1'b1;

    // (r+c)%3-1 weights, all-ones input: 128 = 42*3+2 leaves row sums of -1, 1, 0 for r%3 = 0, 1, 2
    for (int j = 0; j < 128; j++) begin
      in_a[j*8 +: 8] = 8'd1;
      in_b[j*8 +: 8] = 8'd2;
      exp_v[j*8 +: 8] = (j % 3 == 0) ? 8'hff : (j % 3 == 1) ? 8'h01 : 8'h00;
    end
    mode_a = 0;
    run_a(1'b1, lat, bad);
    check("mod3 latency", lat, 16385);
    check("mod3 addr sweep", bad, 0);
    check("mod3 out", out_a, exp_v);
    check("mod3 no x", $isunknown(out_a), 0);
    check("shift7 pos done", done_b, 1);
    check("shift7 pos out", out_b, {128{8'h7f}});
    @(posedge clk); #1;
    check("mod3 done pulse width", done_a, 0);

    // Reset mid-run clears outputs asynchronously
    mode_a = 1;
    for (int j = 0; j < 128; j++) begin
      in_a[j*8 +: 8] = 8'(j - 64);
      in_b[j*8 +: 8] = 8'hfe;
      exp_v[j*8 +: 8] = 8'(j - 64);
    end
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5000) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrun reset out", out_a, '0);
    check("midrun reset done", done_a, 0);
    check("midrun reset addr", wa_a, 0);
    @(negedge clk);
    rst = 1'b1;

    run_a(1'b1, lat, bad);
    check("identity latency", lat, 16385);
    check("identity addr sweep", bad, 0);
    check("identity out", out_a, exp_v);
    check("shift7 neg out", out_b, {128{8'h80}});
    @(posedge clk); #1;
    check("identity done pulse width", done_a, 0);

    // 8x4 instance: saturation cases
    mode_c = 0; in_c = {8{8'h01}};
    run_c(1'b0, lat);
    check("sat +127 latency", lat, 33);
    check("sat +127 out", out_c, 32'h7f7f7f7f);
    mode_c = 1; in_c = {8{8'h01}};
    run_c(1'b0, lat);
    check("sat -128w out", out_c, 32'h80808080);
    mode_c = 0; in_c = {8{8'hff}};
    run_c(1'b0, lat);
    check("sat -1x out", out_c, 32'h80808080);

    // Zero weights, then back-to-back identity run with an ignored start mid-run
    mode_c = 2; in_c = {$urandom, $urandom};
    run_c(1'b0, lat);
    check("zero out", out_c, 32'h0);
    mode_c = 3; in_c = 64'h0102_0304_05fa_7f80;
    run_c(1'b1, lat);
    check("b2b latency", lat, 33);
    check("b2b identity out", out_c, 32'h05fa_7f80);
    repeat (3) @(posedge clk);
    #1;
    check("no queued run done", done_c, 0);
    check("no queued run addr", wa_c, 0);
    check("out held in idle", out_c, 32'h05fa_7f80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
